// File: rtl/arb_mux2_pkg.sv
// Shared constants for the two-source arbitrating mux: source encodings and
// output FIFO geometry, used by the RTL and by the bench.
package arb_mux2_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam logic [1:0]  FULL_COUNT = 2'(FIFO_DEPTH);

  // On a tie the source that did not win last time is granted.
  function automatic logic tie_winner(input logic last_grant);
    return (last_grant == SRC_B) ? SRC_A : SRC_B;
  endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry FIFO holding a payload plus its source bit; head is zero while empty.
module fifo2
  import arb_mux2_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_src,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data,
  output logic             head_src
);

  logic [WIDTH-1:0] data_q [FIFO_DEPTH];
  logic             src_q  [FIFO_DEPTH];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Pop on empty is ignored; push on full only lands when a pop frees a slot.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q < FULL_COUNT) || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= push_data;
      src_q[wr_ptr_q]  <= push_src;
    end
  end

  always_comb begin
    head_data = '0;
    head_src  = SRC_A;
    if (count_q != 2'd0) begin
      head_data = data_q[rd_ptr_q];
      head_src  = src_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/arb_mux2.sv
// Round-robin merge of two valid/ready streams into a 2-entry tagged output FIFO.
module arb_mux2
  import arb_mux2_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             z_valid,
  output logic [WIDTH-1:0] z_data,
  output logic             z_src,
  input  logic             z_ready
);

  logic [1:0]       count;
  logic             can_accept;
  logic             a_wins_tie;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;
  logic             push_src;
  logic             last_grant_q, last_grant_d;

  // A full FIFO still accepts when the consumer pops in the same cycle.
  assign can_accept = (count < FULL_COUNT) || z_ready;
  assign a_wins_tie = (tie_winner(last_grant_q) == SRC_A);

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (reset_n && can_accept) begin
      a_ready = a_valid && (!b_valid || a_wins_tie);
      b_ready = b_valid && (!a_valid || !a_wins_tie);
    end
  end

  assign push      = a_ready || b_ready;
  assign push_data = a_ready ? a_data : b_data;
  assign push_src  = a_ready ? SRC_A : SRC_B;
  assign pop       = z_valid && z_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    if (a_ready)      last_grant_d = SRC_A;
    else if (b_ready) last_grant_d = SRC_B;
  end

  // Reset value B makes A the winner of the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= SRC_B;
    else          last_grant_q <= last_grant_d;
  end

  fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .push_src  (push_src),
    .pop       (pop),
    .count     (count),
    .head_data (z_data),
    .head_src  (z_src)
  );

  assign z_valid = reset_n && (count != 2'd0);

endmodule

// File: doc/arb_mux2.md
ARB_MUX2 -- requirements
Module: arb_mux2

Interface
REQ-001 SHALL have parameter: WIDTH, 1, data width of each input stream and the output stream.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: a_valid  input  1  source A data present.
REQ-005 SHALL have port: a_data  input  WIDTH  source A payload.
REQ-006 SHALL have port: a_ready  output  1  source A transfer accepted this cycle.
REQ-007 SHALL have ports b_valid, b_data, b_ready with identical widths and meaning for source B.
REQ-008 SHALL have port: z_valid  output  1  output FIFO non-empty.
REQ-009 SHALL have port: z_data  output  WIDTH  payload at FIFO head.
REQ-010 SHALL have port: z_src  output  1  origin of head entry, 0 = A, 1 = B.
REQ-011 SHALL have port: z_ready  input  1  consumer accepts head this cycle.

Function
REQ-012 SHALL transfer on an input when its valid and ready are both 1 at a rising edge; same for output with z_valid and z_ready.
REQ-013 SHALL contain a 2-entry output FIFO (data + source bit) with a 2-bit occupancy count 0..2.
REQ-014 SHALL grant at most one input per cycle; a_ready and b_ready never both 1.
REQ-015 SHALL deem FIFO able to accept when count < 2, or count == 2 and z_ready == 1 (pop frees a slot same cycle).
REQ-016 SHALL, when able to accept and only one source valid, grant that source.
REQ-017 SHALL, when able to accept and both valid, grant the source not granted last; priority bit last_grant updates only on an actual input transfer.
REQ-018 SHALL drive a_ready/b_ready combinationally from valids, count, z_ready and last_grant; ready is 0 for a source whose valid is 0.
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-020 SHALL, on push into empty FIFO, assert z_valid on the next cycle with the pushed data (latency 1 cycle).
REQ-021 SHALL present z_data/z_src stable while z_valid == 1 and z_ready == 0.
REQ-022 SHALL ignore z_ready when count == 0 (no underflow); never exceed count 2 (no overflow).
REQ-023 SHALL sustain one transfer per cycle when consumer holds z_ready == 1.

Reset
REQ-024 SHALL, on reset_n low at any time, immediately clear count to 0, last_grant to 1 (so A wins the first tie), FIFO pointers to 0.
REQ-025 SHALL hold z_valid, a_ready, b_ready at 0 while reset_n is low; z_data and z_src drive 0 while count == 0.
REQ-026 SHALL discard any FIFO contents on reset mid-operation; first post-reset output is the first post-reset push.

Structure
REQ-027 SHALL place source encodings SRC_A = 0, SRC_B = 1 and FIFO depth constant 2 in a shared package used by the bench.
REQ-028 SHALL implement the 2-entry FIFO as one sub-module named fifo2 (push, pop, count, head outputs); arbitration stays in arb_mux2.

Verification
REQ-029 Bench SHALL cover: reset, then a_valid=1 a_data=1 one cycle, z_ready=1 -> next cycle z_valid=1 z_data=1 z_src=0, then z_valid=0.
REQ-030 Bench SHALL cover: a_valid=b_valid=1 held, a_data=0 b_data=1, z_ready=1 for 4 cycles -> z_src sequence 0,1,0,1 with matching z_data.
REQ-031 Bench SHALL cover: z_ready=0, both valid for 4 cycles -> exactly 2 pushes (src 0 then 1), a_ready=b_ready=0 afterwards, z_data stable.
REQ-032 Bench SHALL cover: count == 2, z_ready=1 with b_valid=1 -> pop and push same cycle, count stays 2, order preserved.
REQ-033 Bench SHALL cover: count == 2, reset_n pulsed low mid-cycle -> z_valid 0 immediately, next tie grants A.
REQ-034 Bench SHALL cover: all 8 combinations of a_valid, b_valid, z_ready from each count value 0,1,2, checking readys against REQ-015..018 and printing PASS/FAIL per case.
